desconcatenador_numeros: RTL and testbench
==========================================

// Module: desconcatenador_numeros
// PURPOSE
//  Inverse of the digit concatenator: accepts a 32-bit unsigned result, converts it to decimal
//  (iterative double-dabble), suppresses leading zeros and streams one byte per digit, MSD first,
//  to the UART transmitter via a start/done handshake. Sits between the ALU result and uart_tx.
// PARAMETERS
//  ANCHO       32     width of numero (bits)
//  DIGITOS     10     BCD digits held (ceil(ANCHO*log10(2)))
//  ASCII_OUT   1      1: dato = 8'h30 + digit; 0: dato = raw digit 0..9
//  TERM_EN     1      1: send TERMINADOR after last digit
//  TERMINADOR  8'h0D  terminator byte
// PORTS
//  clk        in   1      system clock, rising edge
//  reset      in   1      asynchronous, active-high
//  numero     in   ANCHO  value to send; sampled only on accepted start
//  start      in   1      request; accepted only when busy=0
//  tx_done    in   1      one-cycle pulse from uart_tx: current byte finished
//  dato       out  8      byte to transmit; stable from tx_start until matching tx_done
//  tx_start   out  1      one-cycle pulse: dato valid, begin transmission
//  busy       out  1      high from accepted start until fin
//  fin        out  1      one-cycle pulse after final byte's tx_done
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; dato=0, tx_start=0, busy=0, fin=0; shift/BCD regs cleared.
//  FSM: IDLE -> CONV -> SKIP -> LOAD -> WAIT -> (LOAD | TERM -> TWAIT) -> DONE -> IDLE.
//  IDLE: start=1 at edge k -> latch numero, clear BCD, bit counter=ANCHO-1, busy=1 after edge k.
//  CONV: ANCHO cycles; each cycle add 3 to every BCD nibble >=5, then shift {bcd,bin} left 1.
//  SKIP: digit index starts DIGITOS-1; decrement 1/cycle while digit==0 and index>0.
//        Value 0 therefore yields exactly one digit "0".
//  LOAD: drive dato (ASCII or raw per ASCII_OUT), pulse tx_start for 1 cycle, go WAIT.
//  WAIT: hold dato; on tx_done: if index>0 decrement, go LOAD; else go TERM (TERM_EN) or DONE.
//  TERM/TWAIT: same handshake with dato=TERMINADOR.
//  DONE: fin=1 for one cycle, busy=0 on the next edge, return IDLE.
//  Latency: first tx_start exactly ANCHO + (skipped zeros) + 2 cycles after start edge.
//  start while busy=1: ignored, not queued. numero changes while busy: no effect.
//  tx_done outside WAIT/TWAIT: ignored. tx_done in same cycle as tx_start: ignored (not same byte).
//  start in the DONE cycle: ignored; accepted from IDLE only.
//  Max value 2^32-1 -> 10 digits "4294967295"; no overflow possible with DIGITOS=10.
//  Back-to-back tx_done never skips a byte: one byte per LOAD->WAIT round trip.
// STRUCTURE
//  Shared include uart_defs.vh: FSM state encodings, ASCII_CERO=8'h30, CR=8'h0D, byte width.
//  One sub-module: bin_a_bcd (iterative double-dabble; ports clk, reset, go, bin, bcd, listo),
//  parameterised on ANCHO/DIGITOS. Top holds FSM, digit index, output mux and handshake.
// TESTING (bench clock 20 ns; uart_tx model returns tx_done 3 cycles after each tx_start)
//  1. numero=9814, start pulse -> dato 0x39,0x38,0x31,0x34,0x0D on 5 tx_start pulses, then fin.
//  2. numero=0 -> single 0x30 then 0x0D; fin; first tx_start at start+ANCHO+11 cycles.
//  3. numero=32'hFFFFFFFF -> "4294967295" (10 bytes) + 0x0D; no extra/missing pulses.
//  4. start re-pulsed mid-transfer with numero=7 and spurious tx_done in LOAD -> stream of
//     case 1 unchanged, no extra bytes; a start after fin sends "7" normally.
//  5. reset asserted during WAIT of 2nd digit -> outputs 0 immediately (async); next start
//     with numero=42 sends 0x34,0x32,0x0D cleanly.
//  6. ASCII_OUT=0, TERM_EN=0, numero=105 -> dato 1,0,5; fin after third tx_done; no terminator.

Source files
------------

// File: rtl/desconcatenador_numeros_pkg.sv
// Shared definitions for the number de-concatenator: FSM encodings,
// byte constants and the digit-to-byte helper.
package desconcatenador_numeros_pkg;

  localparam int         BYTE_W     = 8;
  localparam logic [7:0] ASCII_CERO = 8'h30;
  localparam logic [7:0] CR         = 8'h0D;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV,
    ST_SKIP,
    ST_LOAD,
    ST_WAIT,
    ST_TERM,
    ST_TWAIT,
    ST_DONE
  } estado_t;

  // BCD digit to transmitted byte: ASCII character or raw value
  function automatic logic [BYTE_W-1:0] digito_a_byte(input logic [3:0] d, input bit ascii);
    return ascii ? (ASCII_CERO + {4'h0, d}) : {4'h0, d};
  endfunction

endpackage

// File: rtl/desconcatenador_numeros_bin_a_bcd.sv
// Iterative double-dabble: one add-3/shift step per clock, ANCHO steps.
// listo is high during the cycle that performs the final step, so the
// bcd output is complete on the following cycle and holds until next go.
module bin_a_bcd
  import desconcatenador_numeros_pkg::*;
#(
  parameter int ANCHO   = 32,
  parameter int DIGITOS = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   go,
  input  logic [ANCHO-1:0]       bin,
  output logic [4*DIGITOS-1:0]   bcd,
  output logic                   listo
);

  localparam int CW = (ANCHO > 1) ? $clog2(ANCHO) : 1;

  logic [ANCHO-1:0]     sh;
  logic [4*DIGITOS-1:0] bcd_q;
  logic [4*DIGITOS-1:0] bcd_adj;
  logic [CW-1:0]        cnt;
  logic                 running;

  // Add 3 to every nibble that is 5 or more before the shift
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < DIGITOS; i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? (bcd_q[4*i +: 4] + 4'd3)
                                                     : bcd_q[4*i +: 4];
    end
  end

  // Load on go, then shift {bcd, bin} left once per cycle until the counter expires
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh      <= '0;
      bcd_q   <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (go) begin
      sh      <= bin;
      bcd_q   <= '0;
      cnt     <= CW'(ANCHO - 1);
      running <= 1'b1;
    end else if (running) begin
      bcd_q <= {bcd_adj[4*DIGITOS-2:0], sh[ANCHO-1]};
      sh    <= {sh[ANCHO-2:0], 1'b0};
      cnt   <= cnt - CW'(1);
      if (cnt == '0) running <= 1'b0;
    end
  end

  assign bcd   = bcd_q;
  assign listo = running && (cnt == '0);

endmodule

// File: rtl/desconcatenador_numeros.sv
// Converts a binary result to decimal and streams its digits, MSD first,
// to a UART transmitter, with leading zeros suppressed and an optional
// terminator byte.
// Handshake: tx_start is a one-cycle pulse with dato valid; dato then holds
// until a tx_done pulse arrives in a later cycle. A tx_done coinciding with
// tx_start, or arriving while not waiting, is ignored.
module desconcatenador_numeros
  import desconcatenador_numeros_pkg::*;
#(
  parameter int         ANCHO      = 32,
  parameter int         DIGITOS    = 10,
  parameter int         ASCII_OUT  = 1,
  parameter int         TERM_EN    = 1,
  parameter logic [7:0] TERMINADOR = CR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ANCHO-1:0] numero,
  input  logic             start,
  input  logic             tx_done,
  output logic [7:0]       dato,
  output logic             tx_start,
  output logic             busy,
  output logic             fin
);

  localparam int IW = (DIGITOS > 1) ? $clog2(DIGITOS) : 1;

  estado_t              state, state_next;
  logic [IW-1:0]        idx;
  logic [4*DIGITOS-1:0] bcd;
  logic                 listo;
  logic                 go;
  logic                 ack;
  logic [3:0]           digit;
  logic [7:0]           dato_d;
  logic                 tx_start_d, busy_d, fin_d;

  assign go  = (state == ST_IDLE) && start;
  assign ack = tx_done && !tx_start;

  bin_a_bcd #(
    .ANCHO   (ANCHO),
    .DIGITOS (DIGITOS)
  ) u_bin_a_bcd (
    .clk   (clk),
    .reset (reset),
    .go    (go),
    .bin   (numero),
    .bcd   (bcd),
    .listo (listo)
  );

  // Select the BCD digit currently pointed at by the index
  always_comb begin
    digit = '0;
    for (int i = 0; i < DIGITOS; i++) begin
      if (idx == IW'(i)) digit = bcd[4*i +: 4];
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_CONV;
      ST_CONV:  if (listo) state_next = ST_SKIP;
      ST_SKIP:  if (!((digit == 4'd0) && (idx != '0))) state_next = ST_LOAD;
      ST_LOAD:  state_next = ST_WAIT;
      ST_WAIT: begin
        if (ack) begin
          if (idx != '0)        state_next = ST_LOAD;
          else if (TERM_EN != 0) state_next = ST_TERM;
          else                   state_next = ST_DONE;
        end
      end
      ST_TERM:  state_next = ST_TWAIT;
      ST_TWAIT: if (ack) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Output decode; the results are registered so every output is glitch-free
  always_comb begin
    dato_d     = dato;
    tx_start_d = 1'b0;
    if (state == ST_LOAD) begin
      dato_d     = digito_a_byte(digit, ASCII_OUT != 0);
      tx_start_d = 1'b1;
    end else if (state == ST_TERM) begin
      dato_d     = TERMINADOR;
      tx_start_d = 1'b1;
    end
    busy_d = (state_next != ST_IDLE);
    fin_d  = (state_next == ST_DONE);
  end

  // Output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dato     <= '0;
      tx_start <= 1'b0;
      busy     <= 1'b0;
      fin      <= 1'b0;
    end else begin
      dato     <= dato_d;
      tx_start <= tx_start_d;
      busy     <= busy_d;
      fin      <= fin_d;
    end
  end

  // Digit index: starts at the MSD, walks down past leading zeros, then once per sent byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= '0;
    end else if (go) begin
      idx <= IW'(DIGITOS - 1);
    end else if ((state == ST_SKIP) && (digit == 4'd0) && (idx != '0)) begin
      idx <= idx - IW'(1);
    end else if ((state == ST_WAIT) && ack && (idx != '0)) begin
      idx <= idx - IW'(1);
    end
  end

endmodule

// File: tb/tb_desconcatenador_numeros.sv
// Bench for desconcatenador_numeros: instance a (ASCII, terminator) and
// instance b (raw digits, no terminator), each with a uart_tx stand-in that
// answers tx_done 3 cycles after every tx_start.
module tb_desconcatenador_numeros;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_a, start_b;
  logic [31:0] numero_a, numero_b;
  logic        model_done_a, model_done_b, spur_a;
  logic        tx_done_a, tx_done_b;
  logic [7:0]  dato_a, dato_b;
  logic        tx_start_a, tx_start_b, busy_a, busy_b, fin_a, fin_b;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [7:0] got_a[$];
  logic [7:0] got_b[$];
  logic [7:0] exp_q[$];
  logic [7:0] last_a = 8'h00;
  logic [7:0] last_b = 8'h00;
  int         first_tx_a = 0;
  int         start_cyc = 0;
  int         last_done_a = 0;
  int         last_done_b = 0;
  bit         first_pending = 1'b0;
  int         stab_err = 0;

  assign tx_done_a = model_done_a | spur_a;
  assign tx_done_b = model_done_b;

  desconcatenador_numeros u_dut_a (
    .clk      (clk),
    .reset    (reset),
    .numero   (numero_a),
    .start    (start_a),
    .tx_done  (tx_done_a),
    .dato     (dato_a),
    .tx_start (tx_start_a),
    .busy     (busy_a),
    .fin      (fin_a)
  );

  desconcatenador_numeros #(
    .ASCII_OUT (0),
    .TERM_EN   (0)
  ) u_dut_b (
    .clk      (clk),
    .reset    (reset),
    .numero   (numero_b),
    .start    (start_b),
    .tx_done  (tx_done_b),
    .dato     (dato_b),
    .tx_start (tx_start_b),
    .busy     (busy_b),
    .fin      (fin_b)
  );

  // ---------------- clock / reset block ----------------
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- uart_tx stand-ins ----------------
  initial begin : model_a
    int cnt;
    cnt = 0;
    model_done_a = 1'b0;
    forever begin
      @(negedge clk);
      model_done_a = 1'b0;
      if (reset) cnt = 0;
      else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) model_done_a = 1'b1;
        end
        if (tx_start_a) cnt = 3;
      end
    end
  end

  initial begin : model_b
    int cnt;
    cnt = 0;
    model_done_b = 1'b0;
    forever begin
      @(negedge clk);
      model_done_b = 1'b0;
      if (reset) cnt = 0;
      else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) model_done_b = 1'b1;
        end
        if (tx_start_b) cnt = 3;
      end
    end
  end

  // ---------------- byte collectors ----------------
  always begin
    @(negedge clk);
    #1;
    if (tx_start_a) begin
      got_a.push_back(dato_a);
      last_a = dato_a;
      if (first_pending) begin
        first_tx_a    = cyc;
        first_pending = 1'b0;
      end
    end
    if (tx_done_a) begin
      last_done_a = cyc;
      if (dato_a !== last_a) stab_err++;
    end
  end

  always begin
    @(negedge clk);
    #1;
    if (tx_start_b) begin
      got_b.push_back(dato_b);
      last_b = dato_b;
    end
    if (tx_done_b) begin
      last_done_b = cyc;
      if (dato_b !== last_b) stab_err++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_a(input logic [31:0] v);
    @(negedge clk);
    numero_a      = v;
    start_a       = 1'b1;
    start_cyc     = cyc + 1;
    first_pending = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic wait_fin_a(input int bound, output bit to, output int fcyc);
    int i;
    to   = 1'b1;
    fcyc = 0;
    i    = 0;
    while (to && (i < bound)) begin
      @(negedge clk);
      if (fin_a) begin
        to   = 1'b0;
        fcyc = cyc;
      end
      i++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset    = 1'b1;
    start_a  = 1'b0;
    start_b  = 1'b0;
    numero_a = '0;
    numero_b = '0;
    spur_a   = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({dato_a, tx_start_a, busy_a, fin_a} !== 11'd0) begin
      n_err++; $display("FAIL reset_a: got dato=%h start=%b busy=%b fin=%b, want all 0", dato_a, tx_start_a, busy_a, fin_a);
    end
    n_cmp++; if ({dato_b, tx_start_b, busy_b, fin_b} !== 11'd0) begin
      n_err++; $display("FAIL reset_b: got dato=%h start=%b busy=%b fin=%b, want all 0", dato_b, tx_start_b, busy_b, fin_b);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    bit to; int fcyc; logic [7:0] e, g;
    logic [7:0] v[5] = '{8'h39, 8'h38, 8'h31, 8'h34, 8'h0D};
    got_a.delete(); exp_q.delete();
    foreach (v[i]) exp_q.push_back(v[i]);
    pulse_a(32'd9814);
    n_cmp++; if (busy_a !== 1'b1) begin
      n_err++; $display("FAIL basic_busy: got %b, want 1", busy_a);
    end
    wait_fin_a(600, to, fcyc);
    n_cmp++; if (to) begin
      n_err++; $display("FAIL basic_fin: got no fin, want fin within 600 cycles");
    end
    n_cmp++; if (fcyc - last_done_a !== 1) begin
      n_err++; $display("FAIL basic_fin_timing: got %0d cycles after last tx_done, want 1", fcyc - last_done_a);
    end
    repeat (8) @(negedge clk);
    n_cmp++; if (busy_a !== 1'b0) begin
      n_err++; $display("FAIL basic_idle: got busy=%b, want 0", busy_a);
    end
    n_cmp++; if (first_tx_a - start_cyc !== 40) begin
      n_err++; $display("FAIL basic_latency: got %0d, want 40", first_tx_a - start_cyc);
    end
    n_cmp++; if (got_a.size() != exp_q.size()) begin
      n_err++; $display("FAIL basic_count: got %0d bytes, want %0d", got_a.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_a.size() > 0) ? got_a.pop_front() : 8'hxx;
      n_cmp++; if (g !== e) begin
        n_err++; $display("FAIL basic_byte: got %h, want %h", g, e);
      end
    end
  endtask

  task automatic test_zero;
    bit to; int fcyc; logic [7:0] e, g;
    logic [7:0] v[2] = '{8'h30, 8'h0D};
    got_a.delete(); exp_q.delete();
    foreach (v[i]) exp_q.push_back(v[i]);
    pulse_a(32'd0);
    wait_fin_a(600, to, fcyc);
    n_cmp++; if (to) begin
      n_err++; $display("FAIL zero_fin: got no fin, want fin within 600 cycles");
    end
    repeat (8) @(negedge clk);
    n_cmp++; if (first_tx_a - start_cyc !== 43) begin
      n_err++; $display("FAIL zero_latency: got %0d, want 43", first_tx_a - start_cyc);
    end
    n_cmp++; if (got_a.size() != exp_q.size()) begin
      n_err++; $display("FAIL zero_count: got %0d bytes, want %0d", got_a.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_a.size() > 0) ? got_a.pop_front() : 8'hxx;
      n_cmp++; if (g !== e) begin
        n_err++; $display("FAIL zero_byte: got %h, want %h", g, e);
      end
    end
  endtask

  task automatic test_max;
    bit to; int fcyc; logic [7:0] e, g;
    logic [7:0] v[11] = '{8'h34, 8'h32, 8'h39, 8'h34, 8'h39, 8'h36,
                          8'h37, 8'h32, 8'h39, 8'h35, 8'h0D};
    got_a.delete(); exp_q.delete();
    foreach (v[i]) exp_q.push_back(v[i]);
    pulse_a(32'hFFFF_FFFF);
    wait_fin_a(800, to, fcyc);
    n_cmp++; if (to) begin
      n_err++; $display("FAIL max_fin: got no fin, want fin within 800 cycles");
    end
    repeat (8) @(negedge clk);
    n_cmp++; if (first_tx_a - start_cyc !== 34) begin
      n_err++; $display("FAIL max_latency: got %0d, want 34", first_tx_a - start_cyc);
    end
    n_cmp++; if (got_a.size() != exp_q.size()) begin
      n_err++; $display("FAIL max_count: got %0d bytes, want %0d", got_a.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_a.size() > 0) ? got_a.pop_front() : 8'hxx;
      n_cmp++; if (g !== e) begin
        n_err++; $display("FAIL max_byte: got %h, want %h", g, e);
      end
    end
  endtask

  task automatic test_back_to_back;
    bit to; int fcyc; bit seen; logic [7:0] e, g;
    logic [7:0] v[7] = '{8'h39, 8'h38, 8'h31, 8'h34, 8'h0D, 8'h37, 8'h0D};
    got_a.delete(); exp_q.delete();
    foreach (v[i]) exp_q.push_back(v[i]);
    pulse_a(32'd9814);
    seen = 1'b0;
    for (int i = 0; (i < 100) && !seen; i++) begin
      @(negedge clk);
      if (tx_start_a) seen = 1'b1;
    end
    n_cmp++; if (!seen) begin
      n_err++; $display("FAIL b2b_first: got no tx_start, want one within 100 cycles");
    end
    // restart request while busy, then tx_done pulses in LOAD and alongside tx_start
    numero_a = 32'd7;
    start_a  = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (3) @(negedge clk);
    spur_a = 1'b1;
    repeat (2) @(negedge clk);
    spur_a = 1'b0;
    wait_fin_a(600, to, fcyc);
    n_cmp++; if (to) begin
      n_err++; $display("FAIL b2b_fin: got no fin, want fin within 600 cycles");
    end
    repeat (8) @(negedge clk);
    pulse_a(32'd7);
    wait_fin_a(600, to, fcyc);
    n_cmp++; if (to) begin
      n_err++; $display("FAIL b2b_fin2: got no fin, want fin within 600 cycles");
    end
    repeat (8) @(negedge clk);
    n_cmp++; if (first_tx_a - start_cyc !== 43) begin
      n_err++; $display("FAIL b2b_latency: got %0d, want 43", first_tx_a - start_cyc);
    end
    n_cmp++; if (got_a.size() != exp_q.size()) begin
      n_err++; $display("FAIL b2b_count: got %0d bytes, want %0d", got_a.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_a.size() > 0) ? got_a.pop_front() : 8'hxx;
      n_cmp++; if (g !== e) begin
        n_err++; $display("FAIL b2b_byte: got %h, want %h", g, e);
      end
    end
  endtask

  task automatic test_async_reset;
    bit to; int fcyc; int seen; logic [7:0] e, g;
    logic [7:0] v[3] = '{8'h34, 8'h32, 8'h0D};
    pulse_a(32'd9814);
    seen = 0;
    for (int i = 0; (i < 200) && (seen < 2); i++) begin
      @(negedge clk);
      if (tx_start_a) seen++;
    end
    n_cmp++; if (seen != 2) begin
      n_err++; $display("FAIL rst_second: got %0d tx_start pulses, want 2", seen);
    end
    #5;
    reset = 1'b1;
    #1;
    n_cmp++; if (dato_a !== 8'h00) begin
      n_err++; $display("FAIL rst_dato: got %h, want 00", dato_a);
    end
    n_cmp++; if ({tx_start_a, busy_a, fin_a} !== 3'b000) begin
      n_err++; $display("FAIL rst_ctrl: got start=%b busy=%b fin=%b, want 000", tx_start_a, busy_a, fin_a);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    got_a.delete(); exp_q.delete();
    foreach (v[i]) exp_q.push_back(v[i]);
    pulse_a(32'd42);
    wait_fin_a(600, to, fcyc);
    n_cmp++; if (to) begin
      n_err++; $display("FAIL rst_fin: got no fin, want fin within 600 cycles");
    end
    repeat (8) @(negedge clk);
    n_cmp++; if (first_tx_a - start_cyc !== 42) begin
      n_err++; $display("FAIL rst_latency: got %0d, want 42", first_tx_a - start_cyc);
    end
    n_cmp++; if (got_a.size() != exp_q.size()) begin
      n_err++; $display("FAIL rst_count: got %0d bytes, want %0d", got_a.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_a.size() > 0) ? got_a.pop_front() : 8'hxx;
      n_cmp++; if (g !== e) begin
        n_err++; $display("FAIL rst_byte: got %h, want %h", g, e);
      end
    end
  endtask

  task automatic test_raw_no_term;
    bit to; int fcyc; logic [7:0] e, g;
    logic [7:0] v[3] = '{8'h01, 8'h00, 8'h05};
    got_b.delete(); exp_q.delete();
    foreach (v[i]) exp_q.push_back(v[i]);
    @(negedge clk);
    numero_b = 32'd105;
    start_b  = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    to   = 1'b1;
    fcyc = 0;
    for (int i = 0; (i < 600) && to; i++) begin
      @(negedge clk);
      if (fin_b) begin
        to   = 1'b0;
        fcyc = cyc;
      end
    end
    n_cmp++; if (to) begin
      n_err++; $display("FAIL raw_fin: got no fin, want fin within 600 cycles");
    end
    n_cmp++; if (fcyc - last_done_b !== 1) begin
      n_err++; $display("FAIL raw_fin_timing: got %0d cycles after third tx_done, want 1", fcyc - last_done_b);
    end
    repeat (8) @(negedge clk);
    n_cmp++; if (got_b.size() != exp_q.size()) begin
      n_err++; $display("FAIL raw_count: got %0d bytes, want %0d", got_b.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_b.size() > 0) ? got_b.pop_front() : 8'hxx;
      n_cmp++; if (g !== e) begin
        n_err++; $display("FAIL raw_byte: got %h, want %h", g, e);
      end
    end
  endtask

  task automatic test_stability;
    n_cmp++; if (stab_err !== 0) begin
      n_err++; $display("FAIL dato_stable: got %0d changes before tx_done, want 0", stab_err);
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_max();
    test_back_to_back();
    test_async_reset();
    test_raw_no_term();
    test_stability();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
